// File: rtl/cla_pkg.sv
// Shared types and lookahead helpers for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int unsigned CLA_MAX_BLOCK = 32;

    // Per-stage control record; overflow is meaningful only in the final stage.
    typedef struct packed {
        logic valid;
        logic carry;
        logic overflow;
    } stage_ctrl_t;

    function automatic int unsigned cla_stages(input int unsigned width, input int unsigned block);
        return (block == 0) ? 0 : width / block;
    endfunction

    // Sum-of-products lookahead carry into bit 'pos' of a group (generate = a&b, propagate = a|b).
    function automatic logic cla_carry_into(
        input logic [CLA_MAX_BLOCK-1:0] g,
        input logic [CLA_MAX_BLOCK-1:0] p,
        input logic                     cin,
        input int unsigned              pos
    );
        logic c;
        logic term;
        c = cin;
        for (int unsigned k = 0; k < CLA_MAX_BLOCK; k++) begin
            if (k < pos) c = c & p[k];
        end
        for (int unsigned j = 0; j < CLA_MAX_BLOCK; j++) begin
            if (j < pos) begin
                term = g[j];
                for (int unsigned k = j + 1; k < CLA_MAX_BLOCK; k++) begin
                    if (k < pos) term = term & p[k];
                end
                c = c | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead group: sum, group generate/propagate and carry out.
module cla_block
    import cla_pkg::*;
#(
    parameter int unsigned BLOCK = 8
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             grp_g,
    output logic             grp_p,
    output logic             cout
);

    logic [CLA_MAX_BLOCK-1:0] g_ext;
    logic [CLA_MAX_BLOCK-1:0] p_ext;

    always_comb begin
        g_ext = '0;
        p_ext = '0;
        g_ext[BLOCK-1:0] = a & b;
        p_ext[BLOCK-1:0] = a | b;
        sum = '0;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            sum[i] = a[i] ^ b[i] ^ cla_carry_into(g_ext, p_ext, cin, i);
        end
        grp_g = cla_carry_into(g_ext, p_ext, 1'b0, BLOCK);
        grp_p = &p_ext[BLOCK-1:0];
        cout  = cla_carry_into(g_ext, p_ext, cin, BLOCK);
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one BLOCK-bit group per stage, global-stall handshake.
// Optional CLA_SATURATE_EN: clamp o_sum to the signed limit on overflow in the final stage.
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_sub,
    input  logic             i_carry,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow
);

    localparam int unsigned STAGES = cla_stages(WIDTH, BLOCK);

    if (BLOCK < 1) begin : g_bad_block
        $error("pipelined_cla_addsub: BLOCK must be at least 1");
    end else if (BLOCK > CLA_MAX_BLOCK) begin : g_big_block
        $error("pipelined_cla_addsub: BLOCK exceeds CLA_MAX_BLOCK");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a multiple of BLOCK");
    end

    logic             advance;
    logic [WIDTH-1:0] eff_b;
    logic             eff_cin;

    // Stage inputs: operands shift right by BLOCK per stage, sum slices enter at the top and shift down.
    logic [WIDTH-1:0] st_a   [STAGES];
    logic [WIDTH-1:0] st_b   [STAGES];
    logic [WIDTH-1:0] st_s   [STAGES];
    logic [STAGES-1:0] st_c;
    logic [STAGES-1:0] st_v;

    logic [WIDTH-1:0] a_q    [STAGES];
    logic [WIDTH-1:0] b_q    [STAGES];
    logic [WIDTH-1:0] sum_q  [STAGES];
    stage_ctrl_t      ctrl_q [STAGES];

    logic [WIDTH-1:0] a_d    [STAGES];
    logic [WIDTH-1:0] b_d    [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];
    stage_ctrl_t      ctrl_d [STAGES];

    logic [BLOCK-1:0]  blk_s [STAGES];
    logic [STAGES-1:0] blk_g;
    logic [STAGES-1:0] blk_p;
    logic [STAGES-1:0] blk_cout;

    assign advance    = i_ready | ~o_valid;
    assign o_ready    = advance;
    assign eff_b      = i_sub ? ~i_add2 : i_add2;
    assign eff_cin    = i_sub | i_carry;

    assign o_valid    = ctrl_q[STAGES-1].valid;
    assign o_carry    = ctrl_q[STAGES-1].carry;
    assign o_overflow = ctrl_q[STAGES-1].overflow;
    assign o_sum      = sum_q[STAGES-1];

    always_comb begin
        st_a[0] = i_add1;
        st_b[0] = eff_b;
        st_s[0] = '0;
        st_c    = '0;
        st_v    = '0;
        st_c[0] = eff_cin;
        st_v[0] = i_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = sum_q[k-1];
            st_c[k] = ctrl_q[k-1].carry;
            st_v[k] = ctrl_q[k-1].valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_block #(
            .BLOCK (BLOCK)
        ) u_blk (
            .a     (st_a[k][BLOCK-1:0]),
            .b     (st_b[k][BLOCK-1:0]),
            .cin   (st_c[k]),
            .sum   (blk_s[k]),
            .grp_g (blk_g[k]),
            .grp_p (blk_p[k]),
            .cout  (blk_cout[k])
        );
    end

`ifdef CLA_SATURATE_EN
    localparam logic [WIDTH-1:0] POS_LIMIT = {WIDTH{1'b1}} >> 1;
`endif

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            a_d[k]   = st_a[k] >> BLOCK;
            b_d[k]   = st_b[k] >> BLOCK;
            sum_d[k] = (st_s[k] >> BLOCK) | (WIDTH'(blk_s[k]) << (WIDTH - BLOCK));
            ctrl_d[k].valid    = st_v[k];
            // Registered group carry comes from the group lookahead terms, not the bit ripple.
            ctrl_d[k].carry    = blk_g[k] | (blk_p[k] & st_c[k]);
            ctrl_d[k].overflow = st_a[k][BLOCK-1] ^ st_b[k][BLOCK-1] ^ blk_s[k][BLOCK-1] ^ blk_cout[k];
        end
`ifdef CLA_SATURATE_EN
        if (ctrl_d[STAGES-1].overflow) begin
            sum_d[STAGES-1] = st_a[STAGES-1][BLOCK-1] ? ~POS_LIMIT : POS_LIMIT;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= '0;
                a_q[k]    <= '0;
                b_q[k]    <= '0;
                sum_q[k]  <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                ctrl_q[k] <= ctrl_d[k];
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                sum_q[k]  <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub at WIDTH=16, BLOCK=4; honours CLA_SATURATE_EN.
module tb_pipelined_cla_addsub;

    localparam int unsigned W = 16;
    localparam int unsigned B = 4;
    localparam int          S = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] wrap;
        logic [W-1:0] sat;
        logic         c;
        logic         o;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        int           lat;
        int           acc;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_add1;
    logic [W-1:0] i_add2;
    logic         i_sub;
    logic         i_carry;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_sum;
    logic         o_carry;
    logic         o_overflow;

    int   cyc = 0;
    int   stall_from = 1 << 30;
    int   last_cons = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    vec_t dir_v [8] = '{
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1},
        '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 16'h8000, 1'b1, 1'b1},
        '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 16'h5556, 1'b0, 1'b0},
        '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0},
        '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1},
        '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0}
    };

    vec_t str_v [8] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0},
        '{16'h0F00, 16'h0100, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0},
        '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 16'h3333, 1'b0, 1'b0},
        '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0},
        '{16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0},
        '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0},
        '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1},
        '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1}
    };

    vec_t post_v = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0};

    pipelined_cla_addsub #(
        .WIDTH (W),
        .BLOCK (B)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_add1     (i_add1),
        .i_add2     (i_add2),
        .i_sub      (i_sub),
        .i_carry    (i_carry),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sum      (o_sum),
        .o_carry    (o_carry),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Downstream backpressure: three stalled cycles starting at stall_from.
    always @(negedge i_clk) i_ready = !(cyc >= stall_from && cyc < stall_from + 3);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send(input vec_t v, input bit track, input int lat, output int acc);
        exp_t e;
        i_add1  = v.a;
        i_add2  = v.b;
        i_sub   = v.sub;
        i_carry = v.cin;
        i_valid = 1'b1;
        acc     = -1;
        for (int t = 0; t < 100; t++) begin
            #2;
            if (o_ready) begin
                acc = cyc + 1;
                break;
            end
            @(negedge i_clk);
        end
        if (acc < 0) begin
            chk("accept_timeout", {31'd0, o_ready}, 32'd1);
        end else if (track) begin
`ifdef CLA_SATURATE_EN
            e.sum = v.sat;
`else
            e.sum = v.wrap;
`endif
            e.c   = v.c;
            e.o   = v.o;
            e.lat = lat;
            e.acc = acc;
            sb.push_back(e);
        end
        @(negedge i_clk);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() > 0 && t < budget) begin
            @(negedge i_clk);
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            #3;
            if (!i_rst) begin
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", {31'd0, o_valid}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", {16'd0, o_sum}, {16'd0, e.sum});
                        chk("carry", {31'd0, o_carry}, {31'd0, e.c});
                        chk("overflow", {31'd0, o_overflow}, {31'd0, e.o});
                        if (e.lat > 0) chk("latency", cyc + 1 - e.acc, e.lat);
                        last_cons = cyc + 1;
                    end
                end else if (o_valid && !i_ready) begin
                    chk("stall_ready", {31'd0, o_ready}, 32'd0);
                    if (sb.size() > 0) chk("held_sum", {16'd0, o_sum}, {16'd0, sb[0].sum});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int first;
        // Operation offered during reset must never be accepted.
        i_rst   = 1'b1;
        i_valid = 1'b1;
        i_add1  = 16'h7FFF;
        i_add2  = 16'h0001;
        i_sub   = 1'b0;
        i_carry = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_sum", {16'd0, o_sum}, 32'd0);
        chk("reset_carry", {31'd0, o_carry}, 32'd0);
        chk("reset_overflow", {31'd0, o_overflow}, 32'd0);
        i_rst   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        @(negedge i_clk);

        for (int i = 0; i < 8; i++) send(dir_v[i], 1'b1, S, acc);
        i_valid = 1'b0;
        drain(60);

        stall_from = cyc + 4;
        first = 0;
        for (int i = 0; i < 8; i++) begin
            send(str_v[i], 1'b1, 0, acc);
            if (i == 0) first = acc;
        end
        i_valid = 1'b0;
        drain(60);
        chk("stream_cycles", last_cons - first + 1, 8 + S + 3);
        stall_from = 1 << 30;

        for (int i = 0; i < 3; i++) send(str_v[i], 1'b0, 0, acc);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, o_valid}, 32'd0);
        chk("midreset_sum", {16'd0, o_sum}, 32'd0);
        chk("midreset_carry", {31'd0, o_carry}, 32'd0);
        chk("midreset_overflow", {31'd0, o_overflow}, 32'd0);
        @(negedge i_clk);
        repeat (8) @(negedge i_clk);

        send(post_v, 1'b1, S, acc);
        i_valid = 1'b0;
        drain(30);
        repeat (5) @(negedge i_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
